// File: rtl/wash_cycle_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_seq_pkg
// Description : Shared definitions for the wash-program sequencer: phase
//               codes and the 2-bit power/speed state-word constants that the
//               upstream washer controller produces.
// Revision    : 1.0 - initial release
// ============================================================================
package wash_cycle_seq_pkg;

    // Phase codes; 6 and 7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DONE  = 3'd5
    } phase_t;

    // State word from the power/speed controller.
    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_NORM = 2'b01;
    localparam logic [1:0] ST_FAST = 2'b11;

    // 2'b10 is not a legal controller output and counts as off.
    function automatic logic state_is_on(input logic [1:0] st);
        return (st == ST_NORM) || (st == ST_FAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wash_cycle_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_seq_if
// Description : Bundle between the power/speed controller side (master) and
//               the wash-program sequencer (slave).
//               state      : controller state word into the sequencer
//               phase      : current phase code
//               valve/pump/motor_en/motor_dir/motor_fast/door_lock : actuators
//               done       : program finished
//               time_left  : ticks remaining in the current phase
// Revision    : 1.0 - initial release
// ============================================================================
interface wash_cycle_seq_if #(
    parameter int TW = 8
) ();
    logic [1:0]    state;
    logic [2:0]    phase;
    logic          valve;
    logic          pump;
    logic          motor_en;
    logic          motor_dir;
    logic          motor_fast;
    logic          door_lock;
    logic          done;
    logic [TW-1:0] time_left;

    modport master (
        output state,
        input  phase, valve, pump, motor_en, motor_dir, motor_fast,
               door_lock, done, time_left
    );

    modport slave (
        input  state,
        output phase, valve, pump, motor_en, motor_dir, motor_fast,
               door_lock, done, time_left
    );
endinterface
`default_nettype wire

// File: rtl/wash_cycle_seq_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_seq_tick_prescaler
// Description : Divide-by-TICK_DIV counter with synchronous clear.
//               clk, rst : clock, synchronous active-high reset
//               clr      : force count to 0 on the next clock
//               tick     : high in the last cycle of each TICK_DIV period
// Revision    : 1.0 - initial release
// ============================================================================
module wash_cycle_seq_tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    output logic      tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/wash_cycle_seq.sv
`default_nettype none
// ============================================================================
// Module      : wash_cycle_seq
// Description : Timed FILL -> WASH -> RINSE -> SPIN wash-program sequencer.
//               clk, rst : clock, synchronous active-high reset
//               bus      : slave side of wash_cycle_seq_if (state word in,
//                          phase/actuator/done/time_left out)
// Revision    : 1.0 - initial release
// ============================================================================
module wash_cycle_seq
    import wash_cycle_seq_pkg::*;
#(
    parameter int TICK_DIV  = 4,
    parameter int TW        = 8,
    parameter int T_FILL    = 2,
    parameter int T_WASH    = 4,
    parameter int T_RINSE   = 2,
    parameter int T_SPIN_N  = 3,
    parameter int T_SPIN_F  = 2,
    parameter int DIR_TICKS = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wash_cycle_seq_if.slave  bus
);
    localparam int DW = (DIR_TICKS > 1) ? $clog2(DIR_TICKS) : 1;

    phase_t        r_phase;
    phase_t        w_phase_next;
    logic [TW-1:0] r_timer;
    logic [DW-1:0] r_dir_cnt;
    logic          r_dir;
    logic          r_spin_fast;
    logic          w_on;
    logic          w_tick;
    logic          w_expire;
    logic          w_change;
    logic          w_active;
    logic          w_next_active;

    // Timer value loaded on entry to a phase (duration - 1 ticks).
    function automatic logic [TW-1:0] entry_load(input phase_t ph, input logic fast);
        case (ph)
            PH_FILL:  return TW'(T_FILL - 1);
            PH_WASH:  return TW'(T_WASH - 1);
            PH_RINSE: return TW'(T_RINSE - 1);
            PH_SPIN:  return fast ? TW'(T_SPIN_F - 1) : TW'(T_SPIN_N - 1);
            default:  return '0;
        endcase
    endfunction

    assign w_on          = state_is_on(bus.state);
    assign w_expire      = w_tick && (r_timer == '0);
    assign w_change      = (w_phase_next != r_phase);
    assign w_active      = (r_phase >= PH_FILL) && (r_phase <= PH_SPIN);
    assign w_next_active = (w_phase_next >= PH_FILL) && (w_phase_next <= PH_SPIN);

    // Clearing on every phase change makes each phase exactly duration*TICK_DIV
    // cycles long; holding clear outside active phases keeps IDLE/DONE tick-free.
    wash_cycle_seq_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_change || !w_next_active),
        .tick (w_tick)
    );

    // Next phase; power-off is checked before expiry so it wins.
    always_comb begin
        w_phase_next = r_phase;
        case (r_phase)
            PH_IDLE:  if (w_on) w_phase_next = PH_FILL;
            PH_FILL:  if (!w_on) w_phase_next = PH_IDLE; else if (w_expire) w_phase_next = PH_WASH;
            PH_WASH:  if (!w_on) w_phase_next = PH_IDLE; else if (w_expire) w_phase_next = PH_RINSE;
            PH_RINSE: if (!w_on) w_phase_next = PH_IDLE; else if (w_expire) w_phase_next = PH_SPIN;
            PH_SPIN:  if (!w_on) w_phase_next = PH_IDLE; else if (w_expire) w_phase_next = PH_DONE;
            PH_DONE:  if (!w_on) w_phase_next = PH_IDLE;
            default:  w_phase_next = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= PH_IDLE;
            r_timer     <= '0;
            r_dir_cnt   <= '0;
            r_dir       <= 1'b0;
            r_spin_fast <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            if (w_change) begin
                r_timer   <= entry_load(w_phase_next, bus.state[1]);
                r_dir_cnt <= '0;
                r_dir     <= 1'b0;
                // Speed is sampled once at SPIN entry and frozen for the phase.
                if (w_phase_next == PH_SPIN) begin
                    r_spin_fast <= bus.state[1];
                end
            end else if (w_tick) begin
                r_timer <= r_timer - 1'b1;
                if (r_phase == PH_WASH) begin
                    if (r_dir_cnt == DW'(DIR_TICKS - 1)) begin
                        r_dir_cnt <= '0;
                        r_dir     <= ~r_dir;
                    end else begin
                        r_dir_cnt <= r_dir_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Outputs decode the registered phase, so an abort clears them together.
    assign bus.phase      = r_phase;
    assign bus.valve      = (r_phase == PH_FILL);
    assign bus.pump       = (r_phase == PH_RINSE) || (r_phase == PH_SPIN);
    assign bus.motor_en   = (r_phase == PH_WASH) || (r_phase == PH_RINSE) || (r_phase == PH_SPIN);
    assign bus.motor_dir  = (r_phase == PH_WASH) && r_dir;
    assign bus.motor_fast = (r_phase == PH_SPIN) && r_spin_fast;
    assign bus.door_lock  = w_active;
    assign bus.done       = (r_phase == PH_DONE);
    assign bus.time_left  = w_active ? (r_timer + 1'b1) : '0;

endmodule
`default_nettype wire

// File: tb/tb_wash_cycle_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wash_cycle_seq
// Description : Self-checking bench for wash_cycle_seq. Expected per-cycle
//               output words are queued as stimulus is planned and compared
//               against the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_cycle_seq;
    localparam int TICK_DIV  = 4;
    localparam int TW        = 8;
    localparam int DIR_TICKS = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    logic [17:0] exp_q[$];
    logic [17:0] exp_w;
    logic [17:0] obs;

    wash_cycle_seq_if #(.TW(TW)) bus ();

    wash_cycle_seq #(
        .TICK_DIV (TICK_DIV), .TW (TW), .T_FILL (2), .T_WASH (4), .T_RINSE (2),
        .T_SPIN_N (3), .T_SPIN_F (2), .DIR_TICKS (DIR_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.phase, bus.valve, bus.pump, bus.motor_en, bus.motor_dir,
                  bus.motor_fast, bus.door_lock, bus.done, bus.time_left};

    // Expected output word for cycle i (0-based) of phase ph lasting dur ticks.
    function automatic logic [17:0] exp_vec(input int ph, input int i, input int dur, input bit fast);
        logic [2:0]    p;
        logic [TW-1:0] tl;
        bit act;
        bit dir;
        p   = ph[2:0];
        act = (ph >= 1) && (ph <= 4);
        tl  = act ? TW'(dur - i / TICK_DIV) : '0;
        dir = (ph == 2) ? (((i / (TICK_DIV * DIR_TICKS)) % 2) == 1) : 1'b0;
        return {p, ph == 1, (ph == 3) || (ph == 4), (ph >= 2) && (ph <= 4), dir,
                (ph == 4) && fast, act, ph == 5, tl};
    endfunction

    task automatic push_phase(input int ph, input int first, input int last, input int dur, input bit fast);
        for (int i = first; i < last; i++) exp_q.push_back(exp_vec(ph, i, dur, fast));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.state = 2'b01;
        push_phase(0, 0, 3, 0, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
    endtask

    task automatic test_normal_program();
        rst = 1'b0;
        push_phase(1, 0, 8, 2, 0);
        push_phase(2, 0, 16, 4, 0);
        push_phase(3, 0, 8, 2, 0);
        push_phase(4, 0, 12, 3, 0);
        push_phase(5, 0, 4, 0, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL normal_program cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
    endtask

    task automatic test_done_release();
        bus.state = 2'b00;
        push_phase(0, 0, 2, 0, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL done_release cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
        bus.state = 2'b10;
        push_phase(0, 0, 4, 0, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL idle_state10 cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
    endtask

    task automatic test_fast_spin();
        bus.state = 2'b01;
        push_phase(1, 0, 8, 2, 0);
        push_phase(2, 0, 16, 4, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL fast_prelude cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
        bus.state = 2'b11;
        push_phase(3, 0, 8, 2, 0);
        push_phase(4, 0, 3, 2, 1);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL fast_entry cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
        // Dropping back to normal mid-SPIN must not change duration or speed.
        bus.state = 2'b01;
        push_phase(4, 3, 8, 2, 1);
        push_phase(5, 0, 2, 0, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL fast_hold cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
        bus.state = 2'b00;
        push_phase(0, 0, 1, 0, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL fast_off cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
    endtask

    task automatic test_abort();
        bus.state = 2'b01;
        push_phase(1, 0, 8, 2, 0);
        push_phase(2, 0, 11, 4, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL abort_run cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
        bus.state = 2'b00;
        push_phase(0, 0, 1, 0, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL abort_drop cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
        bus.state = 2'b01;
        push_phase(1, 0, 8, 2, 0);
        push_phase(2, 0, 3, 4, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL abort_restart cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
        bus.state = 2'b00;
        push_phase(0, 0, 2, 0, 0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_w) begin
                n_fail++;
                $display("FAIL abort_final cycle %0d: got %h expected %h", cyc, obs, exp_w);
            end
            cyc++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        bus.state = 2'b01;
        test_reset();
        test_normal_program();
        test_done_release();
        test_fast_spin();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
